mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one port of the synchronous program/data RAM between two requesters: M0, the CPU instruction fetch, and M1, the JTAG loader or DMA writer.
- Default: M1 has fixed priority.
- A starvation counter forces M0 through after HOLD_MAX consecutive M1 grants while M0 waits.
- Decodes byte addresses to RAM word addresses and flags out-of-range accesses.
- Returns read data with the RAM's one-cycle latency.
- Sits between the requesters and the dualsyncram A port, replacing the ad-hoc we-based mux.

Parameters:
DWIDTH, 32, data width of RAM and requesters
AWIDTH, 12, RAM word-address width (RAM size = 2^AWIDTH words)
HOLD_MAX, 4, max consecutive M1 grants while M0 is pending before M0 is forced through

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
m0_req  in  1  CPU fetch request, read only
m0_addr  in  32  CPU byte address
m0_ack  out  1  M0 request accepted this cycle
m0_rvalid  out  1  M0 read data valid
m0_rdata  out  DWIDTH  M0 read data
m1_req  in  1  loader request
m1_we  in  1  1 = write, 0 = read
m1_addr  in  32  loader byte address
m1_wdata  in  DWIDTH  loader write data
m1_ack  out  1  M1 request accepted this cycle
m1_rvalid  out  1  M1 read data valid
m1_rdata  out  DWIDTH  M1 read data
ram_addr  out  AWIDTH  RAM word address
ram_wdata  out  DWIDTH  RAM write data
ram_we  out  1  RAM write enable
ram_rdata  in  DWIDTH  RAM read data, registered inside the RAM, 1-cycle latency
err  out  1  one-cycle pulse: out-of-range access was accepted
busy_m1  out  1  last accepted transaction was from M1 (status / LED)

Behaviour:
- Reset values, registered:
  - rvalid pipeline flags: 0
  - starvation counter: 0
  - err: 0
  - busy_m1: 0
- m0_rdata and m1_rdata drive ram_rdata when the corresponding rvalid is set, else 0.
- During reset, no acks are issued and ram_we = 0.
- Arbitration (combinational, same cycle):
  - Only m0_req: grant M0.
  - Only m1_req: grant M1.
  - Both requesting: grant M1 unless cnt == HOLD_MAX, then grant M0.
  - Neither: no grant, ram_we = 0, ram_addr = m0_addr word bits (idle prefetch harmless).
- Grant effects:
  - m*_ack = grant & req.
  - ram_addr = granted addr[AWIDTH+1:2].
  - ram_wdata = m1_wdata.
  - ram_we = M1 granted & m1_we & in-range.
- Starvation counter cnt, width clog2(HOLD_MAX+1):
  - M1 granted while m0_req = 1: cnt + 1, saturating at HOLD_MAX.
  - M0 granted: 0.
  - m0_req = 0: 0.
- Range check: in-range iff addr[31:AWIDTH+2] == 0.
  - Out-of-range access is still acked.
  - Writes are suppressed.
  - Reads return 0 with normal latency.
  - err pulses the cycle after ack.
- Latency:
  - Read acked in cycle N: owner's rvalid = 1 in cycle N+1, rdata = RAM output.
  - Writes produce no rvalid.
  - Back-to-back acks give one result per cycle, in order.
  - rvalid follows the owner recorded at ack, not the current grant.
- Low address bits [1:0] are ignored; there are no byte lanes.
- Requesters hold req/addr/wdata stable until ack; the arbiter does not latch requests.
- Reset mid-operation: rvalid for an ack issued in the reset cycle or the prior cycle is cleared. No rvalid appears the cycle after reset deasserts.
- busy_m1 registers "M1 granted" on each ack. It holds its value when idle.

Test Plan:
- M0 only, addr 0x0000_0010 held 3 cycles:
  - ram_addr = 4 each cycle.
  - m0_ack = 1 each cycle.
  - m0_rvalid = 1 cycles 2–4 with RAM word 4.
- M1 write 0xDEADBEEF to 0x0000_0020, then M1 read of same address:
  - Write cycle: ram_we = 1, ram_addr = 8.
  - Read: m1_rvalid with 0xDEADBEEF next cycle.
  - m0 sees no rvalid.
- Both requesting continuously, HOLD_MAX = 4: grant sequence M1,M1,M1,M1,M0,M1,M1,M1,M1,M0.
- M1 write to 0xA000_0000: m1_ack = 1, ram_we = 0, err = 1 next cycle. A subsequent read of 0xA000_0000 returns m1_rdata = 0.
- reset asserted in the cycle after an M0 read ack: m0_rvalid stays 0. cnt = 0 and busy_m1 = 0 after reset.
- m0_req drops after 2 M1 grants, then returns: cnt restarts from 0, so M0 waits 4 further M1 grants.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter for one synchronous RAM port
// M1 wins by default; a starvation counter lets M0 through after HOLD_MAX M1 grants.
module mem_port_arbiter #(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 12,
  parameter int HOLD_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic [31:0]       m0_addr,
  output logic              m0_ack,
  output logic              m0_rvalid,
  output logic [DWIDTH-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [31:0]       m1_addr,
  input  logic [DWIDTH-1:0] m1_wdata,
  output logic              m1_ack,
  output logic              m1_rvalid,
  output logic [DWIDTH-1:0] m1_rdata,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DWIDTH-1:0] ram_rdata,
  output logic              err,
  output logic              busy_m1
);

  localparam int CW = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_MAX);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          rv0_q, rv0_d;
  logic          rv1_q, rv1_d;
  logic          err_q, err_d;
  logic          busy_m1_q, busy_m1_d;

  logic          gnt0, gnt1;
  logic          m0_in_range, m1_in_range, sel_in_range;
  logic [31:0]   sel_addr;
  logic          any_ack;
  logic          unused_low_bits;

  assign unused_low_bits = ^{m0_addr[1:0], m1_addr[1:0]};

  always_comb begin
    m0_in_range = (m0_addr[31:AWIDTH+2] == '0);
    m1_in_range = (m1_addr[31:AWIDTH+2] == '0);

    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (m1_req && !(m0_req && (cnt_q == CNT_MAX))) begin
      gnt1 = 1'b1;
    end else if (m0_req) begin
      gnt0 = 1'b1;
    end

    // With no grant the M0 address goes out anyway; an idle read is harmless.
    sel_addr     = gnt1 ? m1_addr : m0_addr;
    sel_in_range = gnt1 ? m1_in_range : m0_in_range;
  end

  always_comb begin
    m0_ack    = gnt0 & ~reset;
    m1_ack    = gnt1 & ~reset;
    any_ack   = m0_ack | m1_ack;
    ram_addr  = sel_addr[AWIDTH+1:2];
    ram_wdata = m1_wdata;
    ram_we    = m1_ack & m1_we & m1_in_range;
  end

  always_comb begin
    rv0_d     = m0_ack;
    rv1_d     = m1_ack & ~m1_we;
    err_d     = any_ack & ~sel_in_range;
    busy_m1_d = any_ack ? m1_ack : busy_m1_q;

    cnt_d = cnt_q;
    if (!m0_req || gnt0) begin
      cnt_d = '0;
    end else if (gnt1 && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      rv0_q     <= 1'b0;
      rv1_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_m1_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rv0_q     <= rv0_d;
      rv1_q     <= rv1_d;
      err_q     <= err_d;
      busy_m1_q <= busy_m1_d;
    end
  end

  // A read whose ack was one cycle before reset must not surface during reset.
  // err_q doubles as the "returned word was out of range" mask for that read.
  always_comb begin
    m0_rvalid = rv0_q & ~reset;
    m1_rvalid = rv1_q & ~reset;
    m0_rdata  = (m0_rvalid && !err_q) ? ram_rdata : '0;
    m1_rdata  = (m1_rvalid && !err_q) ? ram_rdata : '0;
    err       = err_q;
    busy_m1   = busy_m1_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench for mem_port_arbiter
// Vector table for single-cycle behaviour, hand sequences for arbitration and reset.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req;
  logic [31:0] m0_addr;
  logic        m0_ack, m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m1_req, m1_we;
  logic [31:0] m1_addr, m1_wdata;
  logic        m1_ack, m1_rvalid;
  logic [31:0] m1_rdata;
  logic [11:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic [31:0] ram_rdata;
  logic        err, busy_m1;

  int n_cmp = 0;
  int n_err = 0;

  mem_port_arbiter #(.DWIDTH(32), .AWIDTH(12), .HOLD_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_ack(m0_ack),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .err(err), .busy_m1(busy_m1)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:4095];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  typedef struct {
    logic        rst;
    logic        m0r;
    logic [31:0] m0a;
    logic        m1r;
    logic        we;
    logic [31:0] m1a;
    logic [31:0] wd;
    logic        e_a0;
    logic        e_a1;
    logic        e_we;
    logic [11:0] e_addr;
    logic        e_rv0;
    logic [31:0] e_rd0;
    logic        e_rv1;
    logic [31:0] e_rd1;
    logic        e_err;
    logic        e_busy;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic m0r, input logic [31:0] m0a,
                       input logic m1r, input logic we, input logic [31:0] m1a,
                       input logic [31:0] wd);
    @(negedge clk);
    reset = rst; m0_req = m0r; m0_addr = m0a;
    m1_req = m1r; m1_we = we; m1_addr = m1a; m1_wdata = wd;
    #1;
  endtask

  initial begin
    logic prev_g0;
    logic exp_g0;

    for (int i = 0; i < 4096; i++) mem[i] = 32'hC0DE_0000 | i;
    reset = 1'b1; m0_req = 1'b0; m0_addr = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;

    vecs[0]  = '{1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0,
                 1'b0, 1'b0, 1'b0, 12'd4, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0,
                 1'b1, 1'b0, 1'b0, 12'd4, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0,
                 1'b1, 1'b0, 1'b0, 12'd4, 1'b1, 32'hC0DE_0004, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0,
                 1'b1, 1'b0, 1'b0, 12'd4, 1'b1, 32'hC0DE_0004, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0,
                 1'b0, 1'b0, 1'b0, 12'd4, 1'b1, 32'hC0DE_0004, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 32'h10, 1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF,
                 1'b0, 1'b1, 1'b1, 12'd8, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 32'h10, 1'b1, 1'b0, 32'h20, 32'hDEAD_BEEF,
                 1'b0, 1'b1, 1'b0, 12'd8, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 32'h10, 1'b0, 1'b0, 32'h20, 32'h0,
                 1'b0, 1'b0, 1'b0, 12'd4, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 32'h10, 1'b1, 1'b1, 32'hA000_0000, 32'h1234_5678,
                 1'b0, 1'b1, 1'b0, 12'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 32'h10, 1'b1, 1'b0, 32'hA000_0000, 32'h0,
                 1'b0, 1'b1, 1'b0, 12'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0,
                 1'b0, 1'b0, 1'b0, 12'd4, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0,
                 1'b0, 1'b0, 1'b0, 12'd4, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1};

    for (int v = 0; v < 12; v++) begin
      drive(vecs[v].rst, vecs[v].m0r, vecs[v].m0a, vecs[v].m1r, vecs[v].we,
            vecs[v].m1a, vecs[v].wd);
      chk($sformatf("v%0d m0_ack", v),    {31'b0, m0_ack},    {31'b0, vecs[v].e_a0});
      chk($sformatf("v%0d m1_ack", v),    {31'b0, m1_ack},    {31'b0, vecs[v].e_a1});
      chk($sformatf("v%0d ram_we", v),    {31'b0, ram_we},    {31'b0, vecs[v].e_we});
      chk($sformatf("v%0d ram_addr", v),  {20'b0, ram_addr},  {20'b0, vecs[v].e_addr});
      chk($sformatf("v%0d m0_rvalid", v), {31'b0, m0_rvalid}, {31'b0, vecs[v].e_rv0});
      chk($sformatf("v%0d m0_rdata", v),  m0_rdata,           vecs[v].e_rd0);
      chk($sformatf("v%0d m1_rvalid", v), {31'b0, m1_rvalid}, {31'b0, vecs[v].e_rv1});
      chk($sformatf("v%0d m1_rdata", v),  m1_rdata,           vecs[v].e_rd1);
      chk($sformatf("v%0d err", v),       {31'b0, err},       {31'b0, vecs[v].e_err});
      chk($sformatf("v%0d busy_m1", v),   {31'b0, busy_m1},   {31'b0, vecs[v].e_busy});
    end

    // Both requesting: M1 x4, M0, M1 x4, M0; read results follow the owner at ack.
    prev_g0 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      exp_g0 = (i % 5 == 4);
      drive(1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0);
      chk($sformatf("starve%0d m0_ack", i), {31'b0, m0_ack}, {31'b0, exp_g0});
      chk($sformatf("starve%0d m1_ack", i), {31'b0, m1_ack}, {31'b0, ~exp_g0});
      chk($sformatf("starve%0d ram_addr", i), {20'b0, ram_addr}, exp_g0 ? 32'd4 : 32'd8);
      if (i > 0) begin
        chk($sformatf("starve%0d m0_rvalid", i), {31'b0, m0_rvalid}, {31'b0, prev_g0});
        chk($sformatf("starve%0d m1_rvalid", i), {31'b0, m1_rvalid}, {31'b0, ~prev_g0});
        chk($sformatf("starve%0d m0_rdata", i), m0_rdata, prev_g0 ? 32'hC0DE_0004 : 32'h0);
        chk($sformatf("starve%0d m1_rdata", i), m1_rdata, prev_g0 ? 32'h0 : 32'hDEAD_BEEF);
      end else begin
        chk("starve0 m0_rvalid", {31'b0, m0_rvalid}, 32'd0);
        chk("starve0 m1_rvalid", {31'b0, m1_rvalid}, 32'd0);
      end
      prev_g0 = exp_g0;
    end

    // M0 read ack, then reset in the following cycle.
    drive(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("r1 m0_ack", {31'b0, m0_ack}, 32'd1);
    chk("r1 m0_rvalid_prev", {31'b0, m0_rvalid}, 32'd1);
    drive(1'b1, 1'b0, 32'h10, 1'b1, 1'b1, 32'h30, 32'h55);
    chk("r1 rst m0_rvalid", {31'b0, m0_rvalid}, 32'd0);
    chk("r1 rst m0_rdata", m0_rdata, 32'd0);
    chk("r1 rst m1_ack", {31'b0, m1_ack}, 32'd0);
    chk("r1 rst ram_we", {31'b0, ram_we}, 32'd0);
    drive(1'b0, 1'b0, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("r1 post m0_rvalid", {31'b0, m0_rvalid}, 32'd0);
    chk("r1 post m1_rvalid", {31'b0, m1_rvalid}, 32'd0);
    chk("r1 post busy_m1", {31'b0, busy_m1}, 32'd0);

    // Counter at 3 and busy_m1 set when reset hits; both must start over.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0);
      chk($sformatf("r2 pre%0d m1_ack", i), {31'b0, m1_ack}, 32'd1);
    end
    drive(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0);
    chk("r2 rst m0_ack", {31'b0, m0_ack}, 32'd0);
    chk("r2 rst m1_ack", {31'b0, m1_ack}, 32'd0);
    chk("r2 rst m1_rvalid", {31'b0, m1_rvalid}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0);
      if (i == 0) begin
        chk("r2 post busy_m1", {31'b0, busy_m1}, 32'd0);
        chk("r2 post m1_rvalid", {31'b0, m1_rvalid}, 32'd0);
      end
      chk($sformatf("r2 post%0d m0_ack", i), {31'b0, m0_ack}, (i == 4) ? 32'd1 : 32'd0);
    end

    // M0 drops after two M1 grants: count restarts, M0 waits four more.
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0);
      chk($sformatf("drop pre%0d m0_ack", i), {31'b0, m0_ack}, 32'd0);
    end
    drive(1'b0, 1'b0, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0);
    chk("drop gap m1_ack", {31'b0, m1_ack}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0);
      chk($sformatf("drop post%0d m0_ack", i), {31'b0, m0_ack}, (i == 4) ? 32'd1 : 32'd0);
      chk($sformatf("drop post%0d m1_ack", i), {31'b0, m1_ack}, (i == 4) ? 32'd0 : 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
